lwc_sha256_msg_sched: RTL and testbench

- Sequential SHA-256 message-schedule generator. It produces the operand stream that the core's SHA256SIG0/SIG1 ALU operations consume.
- Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready stream.
- Emits W0..W63 in order over a second valid/ready stream. Downstream is a compression engine or the coprocessor datapath.
- Uses a 16-entry circular buffer. The buffer is expanded in place.

---
 rtl/lwc_sha256_pkg.sv | 25 ++
 rtl/lwc_sha256_sigma.sv | 14 +
 rtl/lwc_sha256_msg_sched.sv | 182 ++++++++++++++++++
 tb/tb_lwc_sha256_msg_sched.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lwc_sha256_pkg.sv
// Shared SHA-256 types, constants and rotate helper used by the message scheduler
// and by the ALU SHA256 opcode decode.
package lwc_sha256_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      EXPAND = 2'd2
   } sched_state_e;

   localparam int SHA256_WORDS_IN = 16;
   localparam int SHA256_ROUNDS   = 64;

   localparam int SIG0_ROT_A = 7;
   localparam int SIG0_ROT_B = 18;
   localparam int SIG0_SHR   = 3;
   localparam int SIG1_ROT_A = 17;
   localparam int SIG1_ROT_B = 19;
   localparam int SIG1_SHR   = 10;

   function automatic logic [31:0] rotr32(input logic [31:0] x, input int amt);
      return (x >> amt) | (x << (32 - amt));
   endfunction

endpackage

// File: rtl/lwc_sha256_sigma.sv
// Combinational SHA-256 small sigma functions: sig0 of x0_i and sig1 of x1_i.
module lwc_sha256_sigma
   import lwc_sha256_pkg::*;
(
   input  logic [31:0] x0_i,
   input  logic [31:0] x1_i,
   output logic [31:0] sig0_o,
   output logic [31:0] sig1_o
);

   assign sig0_o = rotr32(x0_i, SIG0_ROT_A) ^ rotr32(x0_i, SIG0_ROT_B) ^ (x0_i >> SIG0_SHR);
   assign sig1_o = rotr32(x1_i, SIG1_ROT_A) ^ rotr32(x1_i, SIG1_ROT_B) ^ (x1_i >> SIG1_SHR);

endmodule

// File: rtl/lwc_sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 words, then emits W0..W(ROUNDS-1) expanded in place
// in a 16-entry circular buffer. Define LWC_SHA256_SCHED_PERF_EN to add stall_cnt_o.
module lwc_sha256_msg_sched
   import lwc_sha256_pkg::*;
#(
   parameter int WORDS_IN = SHA256_WORDS_IN,
   parameter int ROUNDS   = SHA256_ROUNDS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic        blk_valid_i,
   output logic        blk_ready_o,
   input  logic [31:0] blk_word_i,
   output logic        w_valid_o,
   input  logic        w_ready_i,
   output logic [31:0] w_word_o,
   output logic [5:0]  w_idx_o,
   output logic        w_last_o,
`ifdef LWC_SHA256_SCHED_PERF_EN
   output logic [31:0] stall_cnt_o,
`endif
   output logic        busy_o
);

   if (WORDS_IN != 16) begin : g_words_chk
      $error("lwc_sha256_msg_sched: WORDS_IN must be 16");
   end
   if (ROUNDS < 16 || ROUNDS > 64) begin : g_rounds_chk
      $error("lwc_sha256_msg_sched: ROUNDS must be in 16..64");
   end

   localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

   sched_state_e state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [5:0]   t_q, t_d;
   logic [31:0]  w_word_q, w_word_d;
   logic         w_valid_q, w_valid_d;
   logic         w_last_q, w_last_d;
   logic         blk_ready_q, blk_ready_d;

   logic [31:0]  blkbuf_q [16];
   logic         buf_we_d;
   logic [3:0]   buf_waddr_d;
   logic [31:0]  buf_wdata_d;

   logic         in_hs, out_hs;
   logic [5:0]   nxt_t;
   logic [3:0]   n4, idx_m15, idx_m7, idx_m2;
   logic [31:0]  sig0, sig1, exp_word, next_word;

   assign in_hs  = blk_valid_i & blk_ready_q;
   assign out_hs = w_valid_q & w_ready_i;
   assign nxt_t  = t_q + 6'd1;

   // Slot n mod 16 still holds W[n-16]; the other taps sit at fixed offsets from it.
   assign n4      = nxt_t[3:0];
   assign idx_m15 = n4 + 4'd1;
   assign idx_m7  = n4 + 4'd9;
   assign idx_m2  = n4 + 4'd14;

   lwc_sha256_sigma u_sigma (
      .x0_i   (blkbuf_q[idx_m15]),
      .x1_i   (blkbuf_q[idx_m2]),
      .sig0_o (sig0),
      .sig1_o (sig1)
   );

   assign exp_word  = sig1 + blkbuf_q[idx_m7] + sig0 + blkbuf_q[n4];
   assign next_word = (nxt_t[5:4] == 2'b00) ? blkbuf_q[n4] : exp_word;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      t_d         = t_q;
      w_word_d    = w_word_q;
      w_valid_d   = w_valid_q;
      w_last_d    = w_last_q;
      buf_we_d    = 1'b0;
      buf_waddr_d = '0;
      buf_wdata_d = '0;
      unique case (state_q)
         IDLE, LOAD: begin
            if (in_hs) begin
               buf_we_d    = 1'b1;
               buf_waddr_d = cnt_q;
               buf_wdata_d = blk_word_i;
               cnt_d       = cnt_q + 4'd1;
               state_d     = LOAD;
               if (cnt_q == 4'd15) begin
                  state_d   = EXPAND;
                  w_valid_d = 1'b1;
                  t_d       = '0;
                  w_word_d  = blkbuf_q[0];
                  w_last_d  = 1'b0;
               end
            end
         end
         EXPAND: begin
            if (out_hs) begin
               if (t_q == LAST_IDX) begin
                  state_d   = IDLE;
                  w_valid_d = 1'b0;
                  w_last_d  = 1'b0;
                  t_d       = '0;
                  cnt_d     = '0;
               end else begin
                  t_d      = nxt_t;
                  w_word_d = next_word;
                  w_last_d = (nxt_t == LAST_IDX);
                  if (nxt_t[5:4] != 2'b00) begin
                     buf_we_d    = 1'b1;
                     buf_waddr_d = n4;
                     buf_wdata_d = exp_word;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Flush wins over any handshake in the same cycle; that data is dropped.
      if (clear_i) begin
         state_d   = IDLE;
         cnt_d     = '0;
         t_d       = '0;
         w_valid_d = 1'b0;
         w_last_d  = 1'b0;
         buf_we_d  = 1'b0;
      end
      blk_ready_d = (state_d != EXPAND);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         t_q         <= '0;
         w_word_q    <= '0;
         w_valid_q   <= 1'b0;
         w_last_q    <= 1'b0;
         blk_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         t_q         <= t_d;
         w_word_q    <= w_word_d;
         w_valid_q   <= w_valid_d;
         w_last_q    <= w_last_d;
         blk_ready_q <= blk_ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we_d) blkbuf_q[buf_waddr_d] <= buf_wdata_d;
   end

`ifdef LWC_SHA256_SCHED_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (clear_i) stall_cnt_d = '0;
      else if (w_valid_q && !w_ready_i && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

   assign blk_ready_o = blk_ready_q;
   assign w_valid_o   = w_valid_q;
   assign w_word_o    = w_word_q;
   assign w_idx_o     = t_q;
   assign w_last_o    = w_last_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_lwc_sha256_msg_sched.sv
// Randomized bench for lwc_sha256_msg_sched with a transaction-level SHA-256 schedule model.
module tb_lwc_sha256_msg_sched;

   localparam int ROUNDS = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear_i = 1'b0;
   logic        blk_valid_i = 1'b0;
   logic [31:0] blk_word_i = '0;
   logic        w_ready_i = 1'b1;
   logic        blk_ready_o, w_valid_o, w_last_o, busy_o;
   logic [31:0] w_word_o;
   logic [5:0]  w_idx_o;
`ifdef LWC_SHA256_SCHED_PERF_EN
   logic [31:0] stall_cnt_o;
   logic [31:0] m_stall = '0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   lwc_sha256_msg_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (clear_i),
      .blk_valid_i (blk_valid_i),
      .blk_ready_o (blk_ready_o),
      .blk_word_i  (blk_word_i),
      .w_valid_o   (w_valid_o),
      .w_ready_i   (w_ready_i),
      .w_word_o    (w_word_o),
      .w_idx_o     (w_idx_o),
      .w_last_o    (w_last_o),
`ifdef LWC_SHA256_SCHED_PERF_EN
      .stall_cnt_o (stall_cnt_o),
`endif
      .busy_o      (busy_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction
   function automatic logic [31:0] m_sig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] m_sig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   logic [31:0] m_w [64];
   logic [31:0] m_q [$];
   bit          m_en = 1'b0;
   int          m_idx = 0;
   int          blocks_done = 0;
   int          cyc = 0;
   int          last_out_cyc = -100;
   int          b2b_gap = -1;

   task automatic build_schedule();
      for (int t = 0; t < 16; t++) m_w[t] = m_q[t];
      for (int t = 16; t < 64; t++)
         m_w[t] = m_sig1(m_w[t-2]) + m_w[t-7] + m_sig0(m_w[t-15]) + m_w[t-16];
   endtask

   // ---------------- compare process ----------------
   logic        rst_smp = 1'b0;
   bit          run = 1'b0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_word;
   logic [5:0]  prev_idx;

   always @(posedge clk) rst_smp <= rst_n;

   always @(negedge clk) begin
      if (run) begin
         cyc++;
         if (!rst_smp) begin
            check("rst_w_valid", 32'(w_valid_o), 32'd0);
            check("rst_blk_ready", 32'(blk_ready_o), 32'd0);
            check("rst_busy", 32'(busy_o), 32'd0);
            check("rst_w_last", 32'(w_last_o), 32'd0);
            check("rst_w_idx", 32'(w_idx_o), 32'd0);
            check("rst_w_word", w_word_o, 32'd0);
         end else begin
            check("w_valid", 32'(w_valid_o), 32'(m_en));
            check("blk_ready", 32'(blk_ready_o), 32'(!m_en));
            check("busy", 32'(busy_o), 32'(m_en || m_q.size() != 0));
            if (m_en && w_valid_o) begin
               check("w_idx", 32'(w_idx_o), 32'(m_idx));
               check("w_word", w_word_o, m_w[m_idx]);
               check("w_last", 32'(w_last_o), 32'(m_idx == ROUNDS - 1));
               if (prev_stall) begin
                  check("stall_word_stable", w_word_o, prev_word);
                  check("stall_idx_stable", 32'(w_idx_o), 32'(prev_idx));
               end
            end
         end
`ifdef LWC_SHA256_SCHED_PERF_EN
         check("stall_cnt", stall_cnt_o, m_stall);
`endif
         // apply the effect of the coming clock edge to the model
         prev_stall = 1'b0;
         if (!rst_n || clear_i) begin
            m_q.delete();
            m_en  = 1'b0;
            m_idx = 0;
`ifdef LWC_SHA256_SCHED_PERF_EN
            m_stall = '0;
`endif
         end else if (rst_smp) begin
            if (m_en && !w_ready_i) begin
               prev_stall = 1'b1;
               prev_word  = w_word_o;
               prev_idx   = w_idx_o;
`ifdef LWC_SHA256_SCHED_PERF_EN
               if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
            end
            if (m_en) begin
               if (w_ready_i) begin
                  m_idx++;
                  if (m_idx == ROUNDS) begin
                     m_en  = 1'b0;
                     m_idx = 0;
                     blocks_done++;
                     last_out_cyc = cyc;
                  end
               end
            end else if (blk_valid_i) begin
               m_q.push_back(blk_word_i);
               if (m_q.size() == 1) b2b_gap = cyc - last_out_cyc;
               if (m_q.size() == 16) begin
                  build_schedule();
                  m_q.delete();
                  m_en  = 1'b1;
                  m_idx = 0;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int rdy_mode = 0;   // 0: always ready, 1: random 50%, 2: hold low

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       w_ready_i = 1'b1;
            1:       w_ready_i = 1'($urandom_range(0, 1));
            default: w_ready_i = 1'b0;
         endcase
      end
   end

   task automatic send_block(input logic [31:0] blk [16], input int clear_at, input bit gaps);
      for (int i = 0; i < 16; i++) begin
         int guard;
         if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
               blk_valid_i = 1'b0;
               @(posedge clk);
               #1;
            end
         end
         blk_valid_i = 1'b1;
         blk_word_i  = blk[i];
         clear_i     = (i == clear_at);
         guard = 0;
         forever begin
            @(negedge clk);
            if (blk_ready_o) break;
            guard++;
            if (guard > 400) begin
               check("input_accept_timeout", 32'd1, 32'd0);
               blk_valid_i = 1'b0;
               clear_i     = 1'b0;
               return;
            end
         end
         @(posedge clk);
         #1;
         if (i == clear_at) begin
            clear_i     = 1'b0;
            blk_valid_i = 1'b0;
            return;
         end
      end
      blk_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      for (int g = 0; g < 2000; g++) begin
         @(negedge clk);
         #1;
         if (!m_en) return;
      end
      check("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_idx(input int n);
      for (int g = 0; g < 2000; g++) begin
         @(negedge clk);
         if (w_valid_o && w_idx_o == 6'(n)) return;
      end
      check("wait_idx_timeout", 32'd1, 32'd0);
   endtask

   logic [31:0] blk_abc [16];
   logic [31:0] blk_ff  [16];
   logic [31:0] blk_r   [16];

   task automatic rand_block();
      for (int i = 0; i < 16; i++) blk_r[i] = $urandom;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         blk_abc[i] = '0;
         blk_ff[i]  = 32'hFFFF_FFFF;
      end
      blk_abc[0]  = 32'h6162_6380;
      blk_abc[15] = 32'h0000_0018;

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      run = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // "abc" with downstream always ready
      rdy_mode = 0;
      send_block(blk_abc, -1, 1'b0);
      wait_idle();
      check("model_abc_w16", m_w[16], 32'h6162_6380);
      check("model_abc_w17", m_w[17], 32'h000F_0000);

      // same block with random backpressure and input gaps
      rdy_mode = 1;
      send_block(blk_abc, -1, 1'b1);
      wait_idle();

      // clear at input word 7, then a fresh block
      rand_block();
      send_block(blk_r, 7, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rand_block();
      send_block(blk_r, -1, 1'b1);
      wait_idle();

      // clear coincident with the handshake of idx 30
      rdy_mode = 0;
      rand_block();
      send_block(blk_r, -1, 1'b0);
      wait_idx(29);
      @(posedge clk);
      #1;
      clear_i = 1'b1;
      @(posedge clk);
      #1;
      clear_i = 1'b0;
      @(negedge clk);
      check("clr_w_valid", 32'(w_valid_o), 32'd0);
      check("clr_blk_ready", 32'(blk_ready_o), 32'd1);
      @(posedge clk);
      #1;
      rdy_mode = 1;
      rand_block();
      send_block(blk_r, -1, 1'b0);
      wait_idle();

      // reset for one cycle at idx 20
      rdy_mode = 0;
      rand_block();
      send_block(blk_r, -1, 1'b0);
      wait_idx(19);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rand_block();
      send_block(blk_r, -1, 1'b1);
      wait_idle();

      // long backpressure hold mid-block
      rand_block();
      send_block(blk_r, -1, 1'b0);
      wait_idx(10);
      rdy_mode = 2;
      repeat (25) @(posedge clk);
      rdy_mode = 1;
      wait_idle();

      // two blocks back-to-back, second all ones
      rdy_mode = 0;
      rand_block();
      send_block(blk_r, -1, 1'b0);
      send_block(blk_ff, -1, 1'b0);
      wait_idle();
      check("b2b_gap_cycles", 32'(b2b_gap), 32'd1);
      check("model_ff_w16", m_w[16], 32'h203F_FFFC);

      repeat (3) @(posedge clk);
      check("blocks_completed", 32'(blocks_done), 32'd8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
